// File: rtl/act_unit_pipe_pkg.sv
// act_pkg: shared types and defaults for the act_unit_pipe activation stage.
// Optional build macro handled by the top: ACT_UNIT_SPARSITY_EN.
package act_pkg;

  // Activation function select, carried with each beat.
  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_e;

  localparam int ACT_DATA_W_DEF     = 17;
  localparam int ACT_LANES_DEF      = 4;
  localparam int ACT_LEAK_SHIFT_DEF = 3;

  // Width needed to count 0..lanes zero lanes in one beat.
  function automatic int zcnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/act_unit_pipe_lane.sv
// act_lane: purely combinational single-lane activation function.
// Output always fits in DATA_W; leaky shift rounds toward -inf.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W     = ACT_DATA_W_DEF,
  parameter int LEAK_SHIFT = ACT_LEAK_SHIFT_DEF
) (
  input  act_mode_e                 mode,
  input  logic [DATA_W-2:0]         clip_val,
  input  logic signed [DATA_W-1:0]  x,
  output logic signed [DATA_W-1:0]  y
);

  logic signed [DATA_W-1:0] clip_ext;
  logic                     x_neg;
  logic                     x_pos;

  // The ceiling is unsigned, so a zero MSB keeps it non-negative in signed compares.
  assign clip_ext = signed'({1'b0, clip_val});
  assign x_neg    = x[DATA_W-1];
  assign x_pos    = !x_neg && (x != '0);

  // Select the activation result for this lane.
  always_comb begin
    // NOTE: y gets a default first so no path through the case can infer a latch.
    y = x;
    case (mode)
      ACT_PASS:  y = x;
      ACT_RELU:  y = x_pos ? x : '0;
      ACT_LEAKY: y = x_neg ? (x >>> LEAK_SHIFT) : x;
      ACT_CLIP: begin
        if (!x_pos)             y = '0;
        else if (x > clip_ext)  y = clip_ext;
        else                    y = x;
      end
    endcase
  end

endmodule

// File: rtl/act_unit_pipe.sv
// act_unit_pipe: 2-stage multi-lane activation pipeline with valid/accept
// handshakes and full-throughput backpressure.
// Optional feature macro: ACT_UNIT_SPARSITY_EN adds per-beat zero counting
// (zero_cnt), a saturating running total (zero_total) and its clear (clr_stats).
module act_unit_pipe
  import act_pkg::*;
#(
  parameter int DATA_W     = ACT_DATA_W_DEF,
  parameter int LANES      = ACT_LANES_DEF,
  parameter int LEAK_SHIFT = ACT_LEAK_SHIFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      ready_in,
  output logic                      in_ack,
  input  logic [1:0]                mode,
  input  logic [DATA_W-2:0]         clip_val,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      ready_out,
  input  logic                      out_ack
`ifdef ACT_UNIT_SPARSITY_EN
  ,
  output logic [zcnt_w(LANES)-1:0]  zero_cnt,
  output logic [31:0]               zero_total,
  input  logic                      clr_stats
`endif
);

  localparam int W = LANES * DATA_W;

  // Stage 1: captured beat and its side-band controls.
  logic              s1_v;
  logic [W-1:0]      s1_data;
  act_mode_e         s1_mode;
  logic [DATA_W-2:0] s1_clip;

  // Stage 2 valid; its payload is out_data itself.
  logic              s2_v;

  logic              s1_adv;
  logic              s2_adv;
  logic [W-1:0]      act_res;

  // A stage may load when it is empty or its content leaves this cycle.
  assign s2_adv    = !s2_v || out_ack;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ack    = s1_adv;
  assign ready_out = s2_v;

  // One combinational lane function per lane, all fed from stage 1.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .DATA_W     (DATA_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .mode     (s1_mode),
      .clip_val (s1_clip),
      .x        (s1_data[g*DATA_W +: DATA_W]),
      .y        (act_res[g*DATA_W +: DATA_W])
    );
  end

  // Stage 1 occupancy: refilled from the input whenever the stage may advance.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst)         s1_v <= 1'b0;
    else if (s1_adv) s1_v <= ready_in;
  end

  // Stage 1 payload: loaded only with a real beat, held otherwise.
  always_ff @(posedge clk) begin
    // NOTE: payload is left out of reset; s1_v alone says whether it means anything.
    if (s1_adv && ready_in) begin
      s1_data <= in_data;
      s1_mode <= act_mode_e'(mode);
      s1_clip <= clip_val;
    end
  end

  // Stage 2: register activation results; bubbles move the valid bit only.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      out_data <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) out_data <= act_res;
    end
  end

`ifdef ACT_UNIT_SPARSITY_EN
  localparam int ZW = zcnt_w(LANES);

  logic [ZW-1:0] zc_next;
  logic [32:0]   total_sum;

  // Count zero lanes in the result about to enter stage 2.
  always_comb begin
    zc_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (act_res[i*DATA_W +: DATA_W] == '0) zc_next = zc_next + ZW'(1);
    end
  end

  // Per-beat zero count travels alongside out_data.
  always_ff @(posedge clk) begin
    if (rst)                   zero_cnt <= '0;
    else if (s2_adv && s1_v)   zero_cnt <= zc_next;
  end

  // One spare bit catches the carry so the total can saturate.
  assign total_sum = {1'b0, zero_total} + 33'(zero_cnt);

  // Running zero total: reset beats clear, clear beats a transfer.
  always_ff @(posedge clk) begin
    if (rst)                         zero_total <= '0;
    else if (clr_stats)              zero_total <= '0;
    else if (ready_out && out_ack)   zero_total <= total_sum[32] ? 32'hFFFF_FFFF
                                                                 : total_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_act_unit_pipe.sv
// Self-checking bench for act_unit_pipe: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model that
// computes each lane's activation with plain integer arithmetic.
// Build with ACT_UNIT_SPARSITY_EN to also check zero_cnt / zero_total.
module tb_act_unit_pipe;

  localparam int DATA_W     = 17;
  localparam int LANES      = 4;
  localparam int LEAK_SHIFT = 3;
  localparam int W          = DATA_W * LANES;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      in_data;
  logic              ready_in;
  logic              in_ack;
  logic [1:0]        mode;
  logic [DATA_W-2:0] clip_val;
  logic [W-1:0]      out_data;
  logic              ready_out;
  logic              out_ack;
`ifdef ACT_UNIT_SPARSITY_EN
  logic [2:0]        zero_cnt;
  logic [31:0]       zero_total;
  logic              clr_stats;
  longint            model_total;
`endif

  always #5 clk = ~clk;

  act_unit_pipe #(
    .DATA_W     (DATA_W),
    .LANES      (LANES),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .ready_in  (ready_in),
    .in_ack    (in_ack),
    .mode      (mode),
    .clip_val  (clip_val),
    .out_data  (out_data),
    .ready_out (ready_out),
    .out_ack   (out_ack)
`ifdef ACT_UNIT_SPARSITY_EN
    ,
    .zero_cnt   (zero_cnt),
    .zero_total (zero_total),
    .clr_stats  (clr_stats)
`endif
  );

  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];   // expected results of beats accepted but not yet delivered
  logic [W-1:0] obs_q[$];   // results actually delivered, for directed checks

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference activation on plain integers.
  function automatic int ref_lane(input int x, input int m, input int c);
    int d;
    d = 1 << LEAK_SHIFT;
    case (m)
      0:       return x;
      1:       return (x > 0) ? x : 0;
      2:       return (x >= 0) ? x : -((-x + d - 1) / d);  // floor(x / 2^LEAK_SHIFT)
      default: return (x <= 0) ? 0 : ((x > c) ? c : x);
    endcase
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input int m, input int c);
    logic [W-1:0] r;
    int x, y;
    for (int i = 0; i < LANES; i++) begin
      x = int'($signed(d[i*DATA_W +: DATA_W]));
      y = ref_lane(x, m, c);
      r[i*DATA_W +: DATA_W] = y[DATA_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input int a, input int b, input int c, input int d);
    logic [W-1:0] r;
    int v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = v[i][DATA_W-1:0];
    return r;
  endfunction

  function automatic int zeros(input logic [W-1:0] b);
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++) if (b[i*DATA_W +: DATA_W] == '0) n++;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] rand_lane();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return {DATA_W{1'b1}};                 // -1
      2:       return {1'b1, {(DATA_W-1){1'b0}}};     // most negative
      3:       return {1'b0, {(DATA_W-1){1'b1}}};     // most positive
      4:       return DATA_W'($urandom_range(0, 20));
      5:       return DATA_W'(-$signed($urandom_range(0, 20)));
      default: return DATA_W'($urandom);
    endcase
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance model, clock.
  task automatic step(input logic [W-1:0] d, input logic rv, input logic [1:0] m,
                      input logic [DATA_W-2:0] c, input logic oa);
    logic take_in, take_out;
    in_data  = d;
    ready_in = rv;
    mode     = m;
    clip_val = c;
    out_ack  = oa;
    #1;
    take_in  = 1'b0;
    take_out = 1'b0;
    if (!rst) begin
      // Two beats fill both stages; only then can a refused out_ack block input.
      check("in_ack", in_ack, !(exp_q.size() == 2 && !oa));
      if (exp_q.size() == 0) begin
        check("ready_out_idle", ready_out, 1'b0);
      end else if (ready_out) begin
        check("out_data", out_data, exp_q[0]);
`ifdef ACT_UNIT_SPARSITY_EN
        check("zero_cnt", zero_cnt, zeros(exp_q[0]));
`endif
      end
`ifdef ACT_UNIT_SPARSITY_EN
      check("zero_total", zero_total, model_total[31:0]);
`endif
      take_out = ready_out && oa && (exp_q.size() != 0);
      take_in  = rv && in_ack;
    end
    if (take_out) begin
      obs_q.push_back(out_data);
`ifdef ACT_UNIT_SPARSITY_EN
      model_total = model_total + zeros(exp_q[0]);
      if (model_total > 64'hFFFF_FFFF) model_total = 64'hFFFF_FFFF;
`endif
      void'(exp_q.pop_front());
    end
    if (take_in) exp_q.push_back(ref_beat(d, int'(m), int'(c)));
`ifdef ACT_UNIT_SPARSITY_EN
    if (rst || clr_stats) model_total = 0;
`endif
    @(posedge clk);
    if (rst) exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0]      rd;
    logic [DATA_W-2:0] rc;

    rst      = 1'b1;
    in_data  = '0;
    ready_in = 1'b0;
    mode     = 2'd0;
    clip_val = '0;
    out_ack  = 1'b0;
`ifdef ACT_UNIT_SPARSITY_EN
    clr_stats   = 1'b0;
    model_total = 0;
`endif
    @(negedge clk);

    // Reset hold then release.
    repeat (3) step('0, 1'b0, 2'd0, '0, 1'b1);
    rst     = 1'b0;
    out_ack = 1'b0;
    #1;
    check("rst_ready_out", ready_out, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ack", in_ack, 1'b1);
    @(negedge clk);

    // Streaming ReLU, 16 beats back to back, with latency check on the first.
    obs_q.delete();
    rd = pack(5, -3, 0, -65536);
    step(rd, 1'b1, 2'd1, '0, 1'b1);
    check("lat_n_plus_1", ready_out, 1'b0);
    step(rd, 1'b1, 2'd1, '0, 1'b1);
    check("lat_n_plus_2", ready_out, 1'b1);
    repeat (14) step(rd, 1'b1, 2'd1, '0, 1'b1);
    repeat (2) step('0, 1'b0, 2'd0, '0, 1'b1);
    check("stream_count", obs_q.size(), 16);
    foreach (obs_q[i]) check("stream_relu", obs_q[i], pack(5, 0, 0, 0));

    // Leaky, clipped, then pass-through with the controls changing per beat.
    obs_q.delete();
    step(pack(-8, -1, -65536, 100), 1'b1, 2'd2, '0, 1'b1);
    step(pack(7, 6, -2, 3), 1'b1, 2'd3, 15'd6, 1'b1);
    step(pack(-2, 0, 9, -65536), 1'b1, 2'd0, 15'd6, 1'b1);
    repeat (2) step('0, 1'b0, 2'd0, '0, 1'b1);
    check("modes_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("leaky", obs_q[0], pack(-1, -1, -8192, 100));
      check("clip", obs_q[1], pack(6, 6, 0, 3));
      check("pass_after_clip", obs_q[2], pack(-2, 0, 9, -65536));
    end

    // Backpressure: downstream refuses for 5 cycles while input keeps offering.
    obs_q.delete();
    for (int i = 0; i < 5; i++) step(pack(10 + i, -1 - i, i, 3), 1'b1, 2'd0, '0, 1'b0);
    out_ack = 1'b0;
    #1;
    check("bp_in_ack", in_ack, 1'b0);
    check("bp_buffered", exp_q.size(), 2);
    check("bp_ready_out", ready_out, 1'b1);
    @(negedge clk);
    repeat (3) step('0, 1'b0, 2'd0, '0, 1'b1);
    check("bp_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("bp_first", obs_q[0], pack(10, -1, 0, 3));
      check("bp_second", obs_q[1], pack(11, -2, 1, 3));
    end

    // Reset while stalled with two beats in flight.
    obs_q.delete();
    step(pack(1, 2, 3, 4), 1'b1, 2'd0, '0, 1'b0);
    step(pack(5, 6, 7, 8), 1'b1, 2'd0, '0, 1'b0);
    step('0, 1'b0, 2'd0, '0, 1'b0);
    rst = 1'b1;
    step('0, 1'b0, 2'd0, '0, 1'b0);
    rst = 1'b0;
    check("rst_stall_ready_out", ready_out, 1'b0);
    check("rst_stall_out_data", out_data, '0);
    repeat (3) step('0, 1'b0, 2'd0, '0, 1'b1);
    check("rst_stall_nothing_out", obs_q.size(), 0);

`ifdef ACT_UNIT_SPARSITY_EN
    // Zero statistics: three beats with two zero lanes each, then clear.
    repeat (3) step(pack(0, 0, 1, 2), 1'b1, 2'd0, '0, 1'b1);
    repeat (2) step('0, 1'b0, 2'd0, '0, 1'b1);
    check("zero_total_6", zero_total, 32'd6);
    clr_stats = 1'b1;
    step('0, 1'b0, 2'd0, '0, 1'b1);
    clr_stats = 1'b0;
    check("zero_total_clr", zero_total, 32'd0);
`endif

    // Randomized traffic with random stalls, bubbles, modes and rare resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < LANES; i++) rd[i*DATA_W +: DATA_W] = rand_lane();
      case ($urandom_range(0, 3))
        0:       rc = '0;
        1:       rc = '1;
        default: rc = (DATA_W-1)'($urandom_range(0, 40));
      endcase
      rst = ($urandom_range(0, 99) == 0);
`ifdef ACT_UNIT_SPARSITY_EN
      clr_stats = ($urandom_range(0, 31) == 0);
`endif
      step(rd, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rc,
           ($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
`ifdef ACT_UNIT_SPARSITY_EN
    clr_stats = 1'b0;
`endif
    repeat (4) step('0, 1'b0, 2'd0, '0, 1'b1);
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/act_unit_pipe.md
Name: act_unit_pipe

Overview:
Parametrised multi-lane activation stage that follows the aggregation/combination datapath of the GNN accelerator. Each accepted beat carries LANES signed lanes, and every lane gets the same activation function. The selectable functions are pass-through, ReLU, leaky ReLU and clipped ReLU. The block is a 2-stage pipeline with valid/accept handshakes on both sides and full-throughput backpressure.

Parameters:
DATA_W, 17, signed lane width (in and out).
LANES, 4, lanes per beat.
LEAK_SHIFT, 3, leaky-ReLU slope is 2^-LEAK_SHIFT; legal range 1..DATA_W-1.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
in_data  in  LANES*DATA_W  packed signed lanes; lane i = in_data[i*DATA_W +: DATA_W].
ready_in  in  1  input beat valid.
in_ack  out  1  block accepts a beat this cycle.
mode  in  2  activation select, sampled with the beat: 0 pass, 1 ReLU, 2 leaky, 3 clipped.
clip_val  in  DATA_W-1  unsigned ceiling for mode 3, sampled with the beat.
out_data  out  LANES*DATA_W  packed signed results.
ready_out  out  1  output beat valid.
out_ack  in  1  downstream accepts the output beat.

Behaviour:
- Input transfer: happens when ready_in && in_ack.
- Output transfer: happens when ready_out && out_ack.
- Pipeline stages:
  - S1 registers the lanes, mode and clip_val.
  - S2 registers the activation results.
- Stage advance rules:
  - s2_adv = !s2_v || out_ack.
  - s1_adv = !s1_v || s2_adv.
  - in_ack = s1_adv, which is combinational from out_ack and the valid bits.
- Latency: accept at cycle N gives ready_out at N+2 when there is no stall. Throughput is 1 beat/cycle while out_ack=1.
- Stall: while ready_out && !out_ack, out_data and ready_out hold stable. S1 holds if it is occupied. No beat is dropped or duplicated.
- Per-lane function, x signed DATA_W:
  - mode 0: y = x.
  - mode 1: y = (x > 0) ? x : 0.
  - mode 2: y = (x >= 0) ? x : (x >>> LEAK_SHIFT). This is an arithmetic shift rounding toward -inf, so -1 maps to -1.
  - mode 3: y = (x <= 0) ? 0 : (x > clip_val ? clip_val : x). clip_val is zero-extended to DATA_W.
- Width: output never exceeds DATA_W, so no saturation is needed.
  - The most-negative input in mode 2 yields -(2^(DATA_W-1-LEAK_SHIFT)).
- Mode and clip_val travel with their beat. Changing them between beats affects only later beats.
- Reset: rst=1 at a clock edge clears s1_v and s2_v and sets out_data=0. This puts ready_out=0, and in_ack=1 from the next cycle.
- Reset mid-stall discards all in-flight beats.
- in_ack is don't-care while rst is asserted.
- ready_in=0 produces bubbles. A bubble never sets ready_out.

Optional Feature:
Macro: ACT_UNIT_SPARSITY_EN.

When defined:
- Adds output zero_cnt, width $clog2(LANES+1). It gives the number of lanes in the current output beat equal to 0, aligned with out_data.
- Adds output zero_total, 32 bits. It is incremented by zero_cnt on each output transfer and saturates at 2^32-1.
- Adds input clr_stats, 1 bit. It is a synchronous clear.
- Priority: rst, then clr_stats, then increment. clr_stats together with a transfer leaves zero_total = 0.
- zero_total resets to 0.

When undefined:
- These ports and registers do not exist.
- Behaviour is otherwise identical.

Decomposition:
- Package act_pkg:
  - typedef enum logic [1:0] act_mode_e {ACT_PASS, ACT_RELU, ACT_LEAKY, ACT_CLIP}.
  - localparam defaults for DATA_W, LANES and LEAK_SHIFT.
  - Function for the zero-count width.
- Sub-module act_lane: a purely combinational single-lane function, with mode, clip_val and x as inputs and y as output.
  - act_unit_pipe instantiates LANES copies via generate.
  - act_unit_pipe owns all registers and the handshake logic.

Test Plan:
- Reset hold then release, no input -> ready_out=0, out_data=0, in_ack=1.
- Streaming, out_ack=1, mode 1, lanes {5,-3,0,-65536} -> {5,0,0,0} 2 cycles after accept, one beat/cycle over 16 beats.
- Mode 2 with LEAK_SHIFT=3, lanes {-8,-1,-65536,100} -> {-1,-1,-8192,100}.
- Mode 3 with clip_val=6, lanes {7,6,-2,3} -> {6,6,0,3}. Next beat with mode 0 and {-2,...} passes -2 through unchanged.
- Backpressure: out_ack=0 for 5 cycles with ready_in=1 -> exactly 2 beats buffered, in_ack=0, out_data stable. Release -> beats emerge in order, none lost.
- Reset asserted during a stall -> ready_out=0 next cycle, buffered beats gone. With ACT_UNIT_SPARSITY_EN: after 3 beats of {0,0,1,2}, zero_total=6; clr_stats gives 0.
